// File: rtl/dtmr_mgr.sv
// dtmr_mgr: switches a voter between simplex and TMR, retiring modules that keep faulting
module dtmr_mgr #(
  parameter int SETTLE = 4,
  parameter int HOLD = 16,
  parameter int MAX_FLT = 3,
  parameter int RST_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [2:0] fault,
  input  logic       flt_clr,
  output logic       state,
  output logic [2:0] en,
  output logic [2:0] mod_rst,
  output logic [5:0] flt_cnt,
  output logic [2:0] disabled,
  output logic       alarm,
  output logic [2:0] fsm_st
);
  localparam logic [2:0] SIMPLEX = 3'd0, ACTIVATE = 3'd1, TMR = 3'd2, RECOVER = 3'd3;
  localparam int MX = SETTLE > HOLD ? (SETTLE > RST_LEN ? SETTLE : RST_LEN)
                                    : (HOLD > RST_LEN ? HOLD : RST_LEN);
  localparam int CW = $clog2(MX + 2);
  localparam logic [1:0] MAXC = 2'(MAX_FLT);
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] h, p, f, fs_n, en_n, mr_n, dis_n;
  logic [5:0] fc_n;
  logic st_n, last;
  function automatic logic two_up(input logic [2:0] m);
    return (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
  endfunction
  assign h = ~disabled;
  assign p = h & (~h + 3'd1);
  assign f = fault & en;
  assign last = cnt <= CW'(1);
  always_comb begin
    fs_n = fsm_st;
    st_n = state;
    en_n = en;
    mr_n = mod_rst;
    fc_n = flt_cnt;
    dis_n = disabled;
    cnt_n = cnt;
    if (flt_clr) begin
      fs_n = SIMPLEX;
      st_n = 1'b0;
      en_n = 3'b001;
      mr_n = '0;
      fc_n = '0;
      dis_n = '0;
      cnt_n = '0;
    end else begin
      case (fsm_st)
        SIMPLEX: begin
          en_n = p;
          mr_n = '0;
          st_n = 1'b0;
          if (trig && !alarm) begin
            fs_n = ACTIVATE;
            st_n = 1'b1;
            en_n = h;
            cnt_n = CW'(SETTLE);
          end
        end
        ACTIVATE: begin
          fs_n = last ? TMR : ACTIVATE;
          cnt_n = last ? CW'(HOLD) : cnt - CW'(1);
        end
        TMR: begin
          if (f != '0) begin
            for (int i = 0; i < 3; i++)
              if (f[i]) begin
                fc_n[2*i +: 2] = flt_cnt[2*i +: 2] >= MAXC ? MAXC : flt_cnt[2*i +: 2] + 2'd1;
                dis_n[i] = fc_n[2*i +: 2] == MAXC;
              end
            fs_n = RECOVER;
            mr_n = f;
            en_n = h & ~f;
            cnt_n = CW'(RST_LEN);
          end else if (trig) begin
            cnt_n = CW'(HOLD);
          end else if (last) begin
            fs_n = SIMPLEX;
            st_n = 1'b0;
            en_n = p;
            cnt_n = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        RECOVER: begin
          if (last) begin
            mr_n = '0;
            fs_n = two_up(h) ? ACTIVATE : SIMPLEX;
            st_n = two_up(h);
            en_n = two_up(h) ? h : p;
            cnt_n = two_up(h) ? CW'(SETTLE) : '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: begin
          fs_n = SIMPLEX;
          st_n = 1'b0;
          en_n = p;
          mr_n = '0;
          cnt_n = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_st <= SIMPLEX;
      state <= 1'b0;
      en <= 3'b001;
      mod_rst <= '0;
      flt_cnt <= '0;
      disabled <= '0;
      alarm <= 1'b0;
      cnt <= '0;
    end else begin
      fsm_st <= fs_n;
      state <= st_n;
      en <= en_n;
      mod_rst <= mr_n;
      flt_cnt <= fc_n;
      disabled <= dis_n;
      alarm <= !two_up(~dis_n);
      cnt <= cnt_n;
    end
  end
endmodule
